// File: rtl/lcd_pkg.sv
// Shared LCD definitions: RGB565 pixel type, default frame geometry and the
// line-fetch state encoding.
package lcd;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } color;

    localparam int H_PIXELS_DEF = 800;
    localparam int V_LINES_DEF  = 480;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FINISH
    } fetch_state_e;

endpackage

// File: rtl/lcd_line_fetch.sv
// Fetches one framebuffer line over a classic-cycle Wishbone read master and
// streams the pixel words into an external two-bank line buffer.
module lcd_line_fetch
    import lcd::*;
#(
    parameter logic [31:0] FB_BASE  = 32'h0000_0000,
    parameter int          H_PIXELS = H_PIXELS_DEF,
    parameter int          V_LINES  = V_LINES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_req,
    input  logic [8:0]  line_num,
    output logic        busy,
    output logic        done,
    output logic        overrun,
    output logic        bus_err,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [1:0]  wb_sel_o,
    output logic [2:0]  wb_cti_o,
    input  logic [15:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        buf_we,
    output logic        buf_bank,
    output logic [9:0]  buf_addr,
    output logic [15:0] buf_data
);

    localparam logic [9:0]  X_LAST = 10'(H_PIXELS - 1);
    localparam logic [31:0] H_W    = 32'(H_PIXELS);
    localparam logic [31:0] V_W    = 32'(V_LINES);

    fetch_state_e state_q;
    logic [9:0]   x_q;
    logic [31:0]  adr_q;
    logic         cyc_q;
    logic         busy_q;
    logic         done_q;
    logic         overrun_q;
    logic         bus_err_q;
    logic         buf_we_q;
    logic         bank_q;
    logic [9:0]   buf_addr_q;
    color         buf_data_q;

    logic [31:0]  line_base_d;
    logic         line_ok_d;
    logic         term_d;

    // The only multiply: start address of the requested line, taken at acceptance.
    assign line_base_d = FB_BASE + ((32'(line_num) * H_W) << 1);
    assign line_ok_d   = 32'(line_num) < V_W;
    assign term_d      = cyc_q & (wb_ack_i | wb_err_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            adr_q      <= '0;
            cyc_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            buf_we_q   <= 1'b0;
            bank_q     <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
        end else begin
            done_q   <= 1'b0;
            buf_we_q <= 1'b0;
            // The done cycle still counts as busy for request acceptance.
            if (line_req && (busy_q || done_q)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (line_req && !done_q) begin
                        if (line_ok_d) begin
                            state_q <= ST_FETCH;
                            cyc_q   <= 1'b1;
                            busy_q  <= 1'b1;
                            x_q     <= '0;
                            adr_q   <= line_base_d;
                            bank_q  <= line_num[0];
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (term_d) begin
                        buf_we_q   <= 1'b1;
                        buf_addr_q <= x_q;
                        buf_data_q <= wb_err_i ? color'(16'h0000) : color'(wb_dat_i);
                        if (wb_err_i) begin
                            bus_err_q <= 1'b1;
                        end
                        x_q   <= x_q + 10'd1;
                        adr_q <= adr_q + 32'd2;
                        if (x_q == X_LAST) begin
                            cyc_q   <= 1'b0;
                            state_q <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overrun  = overrun_q;
    assign bus_err  = bus_err_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = 1'b0;
    assign wb_adr_o = adr_q;
    assign wb_sel_o = cyc_q ? 2'b11 : 2'b00;
    assign wb_cti_o = 3'b000;
    assign buf_we   = buf_we_q;
    assign buf_bank = bank_q;
    assign buf_addr = buf_addr_q;
    assign buf_data = buf_data_q;

endmodule

// File: doc/lcd_line_fetch.md
LCD_LINE_FETCH -- requirements
Module: lcd_line_fetch

Interface
REQ-001 Parameter FB_BASE, 32'h0000_0000: byte address of framebuffer pixel (0,0) in SDRAM.
REQ-002 Parameter H_PIXELS, 800: pixels per line; one 16-bit RGB565 word per pixel.
REQ-003 Parameter V_LINES, 480: lines per frame.
REQ-004 One clock; reset is asynchronous and active-high; ports are named clk and rst.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 line_req  in  1  single-cycle request to fetch one line.
REQ-008 line_num  in  9  line index, sampled when line_req=1.
REQ-009 busy  out  1  high from acceptance until done.
REQ-010 done  out  1  one-cycle pulse when a line completes.
REQ-011 overrun  out  1  sticky; set when line_req arrives while busy.
REQ-012 bus_err  out  1  sticky; set on any wb_err_i.
REQ-013 wb_cyc_o, wb_stb_o  out  1 each  Wishbone B3 cycle and strobe.
REQ-014 wb_we_o  out  1  constant 0 (read-only master).
REQ-015 wb_adr_o  out  32  byte address.
REQ-016 wb_sel_o  out  2  constant 2'b11 while stb=1.
REQ-017 wb_cti_o  out  3  constant 3'b000 (classic cycle).
REQ-018 wb_dat_i  in  16  read data; wb_ack_i  in  1  ack; wb_err_i  in  1  error termination.
REQ-019 buf_we  out  1  write strobe to the external two-bank line buffer.
REQ-020 buf_bank  out  1  bank select; equals line_num[0] of the current line.
REQ-021 buf_addr  out  10  pixel index x.
REQ-022 buf_data  out  16  pixel word.

Function
REQ-023 The state machine SHALL have the states IDLE, FETCH and FINISH.
REQ-024 IDLE: when line_req=1 and line_num<V_LINES, latch line_num, set x=0 and go to FETCH; cyc, stb and busy rise on the next cycle.
REQ-025 IDLE: when line_req=1 and line_num>=V_LINES, start no bus activity and pulse done on the next cycle.
REQ-026 wb_adr_o SHALL equal FB_BASE + ((line*H_PIXELS + x) << 1), computed modulo 2^32.
REQ-027 FETCH: cyc and stb SHALL stay high continuously; each ack or err advances x by 1 and updates wb_adr_o on the next cycle.
REQ-028 An ack or err received while stb=0 SHALL be ignored.
REQ-029 For each ack in cycle N, buf_we=1 in cycle N+1 with buf_data = wb_dat_i registered at N and buf_addr = x at N.
REQ-030 For each err in cycle N, buf_we=1 in cycle N+1 with buf_data=16'h0000; bus_err is set and the fetch continues.
REQ-031 On the termination for x=H_PIXELS-1 in cycle N: cyc and stb drop at N+1 and the state goes to FINISH.
REQ-032 FINISH: pulse done at N+2, drop busy at N+2 and return to IDLE.
REQ-033 line_req while busy=1 SHALL be ignored and set overrun; the current line is unaffected.
REQ-034 line_req in the same cycle as done SHALL be treated as busy and set overrun.
REQ-035 x SHALL be 10 bits; H_PIXELS SHALL be limited to 1..1024.
REQ-036 Back-to-back acks SHALL sustain one word per cycle; there is no extra idle cycle between words.

Reset
REQ-037 While rst=1: state=IDLE, and cyc, stb, busy, done, overrun, bus_err and buf_we are 0; wb_adr_o, buf_addr, buf_data and buf_bank are 0.
REQ-038 rst asserted mid-line SHALL drop cyc and stb immediately (asynchronously) with no further buf_we; the line is discarded.
REQ-039 The sticky flags overrun and bus_err SHALL be cleared only by rst.

Structure
REQ-040 H_PIXELS and V_LINES defaults and the fetch-state enum SHALL be placed in the shared lcd package, alongside lcd::color.
REQ-041 No sub-module is needed; the address multiply is a constant multiply by H_PIXELS, performed once at line acceptance.

Verification
REQ-042 FB_BASE=0, line_num=3, ack every cycle -> first wb_adr_o=0x12C0; 800 buf_we with buf_bank=1; done 2 cycles after the last ack.
REQ-043 line_num=0, ack every 3rd cycle -> buf_addr sequence 0..799 with no gaps or duplicates; busy high throughout.
REQ-044 wb_err_i on x=5 -> buf_data=0 at buf_addr=5, bus_err=1; the remaining pixels are written normally.
REQ-045 line_req at x=100 of a busy line -> overrun=1; the fetch still completes 800 words for the original line.
REQ-046 rst pulsed at x=400 -> cyc/stb low in the same cycle; then line_req with line_num=1 -> a clean fetch starting at 0x640.
REQ-047 line_num=480 -> no cyc; done pulses 1 cycle later.
